// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StIllegal
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // funct3 values the ALU decoder understands: add/sub, slt, or, and.
    function automatic logic alu_funct3_legal(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b010) ||
               (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-unit bundle: instruction fields and status in, datapath controls out.
interface mc_control_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

endinterface

// File: rtl/mc_control_alu_decoder.sv
// Combinational ALUOp/funct decode to the 3-bit ALUControl code.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        case (alu_op_i)
            AluOpAdd: alu_control_o = AluAdd;
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // Only R-type may subtract; on I-type bit 30 is immediate data.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready stall and a terminal trap state for unsupported encodings.
module mc_control
    import mc_pkg::*;
(
    input logic          clk,
    input logic          rst,
    mc_control_if.master bus
);

    state_e state_q, state_d;
    state_e decode_next;
    state_e state_out;

    logic       pc_write, ir_write, mem_write, reg_write, illegal_st, adr_src;
    logic [1:0] result_src, src_a, src_b, imm_src;
    logic [2:0] alu_control;
    alu_op_e    alu_op;

    // Full legality check happens here, so later states can trust the fields.
    always_comb begin
        decode_next = StIllegal;
        case (bus.op)
            OpLoad, OpStore: begin
                if (bus.funct3 == 3'b010) decode_next = StMemAdr;
            end
            OpRType: begin
                if (alu_funct3_legal(bus.funct3) && (!bus.funct7b5 || bus.funct3 == 3'b000)) begin
                    decode_next = StExecR;
                end
            end
            OpIType: begin
                if (alu_funct3_legal(bus.funct3)) decode_next = StExecI;
            end
            OpBranch: begin
                if (bus.funct3[2:1] == 2'b00) decode_next = StBranch;
            end
            default: decode_next = StIllegal;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode:   state_d = decode_next;
            StMemAdr:   state_d = bus.op[5] ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StIllegal:  state_d = StIllegal;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // During reset the datapath sees FETCH controls with all writes suppressed.
    always_comb begin
        state_out  = rst ? StFetch : state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal_st = 1'b0;
        adr_src    = 1'b0;
        result_src = ResAluOut;
        src_a      = SrcAPc;
        src_b      = SrcBRs2;
        imm_src    = ImmI;
        alu_op     = AluOpAdd;
        case (state_out)
            StFetch: begin
                src_b      = SrcBFour;
                result_src = ResAluResult;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
            end
            StDecode: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_src = ImmB;
            end
            StMemAdr: begin
                src_a   = SrcARs1;
                src_b   = SrcBImm;
                imm_src = bus.op[5] ? ImmS : ImmI;
            end
            StMemRead: adr_src = 1'b1;
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                src_a  = SrcARs1;
                src_b  = SrcBRs2;
                alu_op = AluOpFunct;
            end
            StExecI: begin
                src_a   = SrcARs1;
                src_b   = SrcBImm;
                imm_src = ImmI;
                alu_op  = AluOpFunct;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
            end
            StBranch: begin
                src_a      = SrcARs1;
                src_b      = SrcBRs2;
                alu_op     = AluOpSub;
                result_src = ResAluOut;
                // funct3[0] distinguishes bne from beq.
                pc_write   = bus.Zero ^ bus.funct3[0];
            end
            StIllegal: illegal_st = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .op5_i         (bus.op[5]),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (alu_control)
    );

    assign bus.PCWrite    = pc_write & ~rst;
    assign bus.IRWrite    = ir_write & ~rst;
    assign bus.MemWrite   = mem_write & ~rst;
    assign bus.RegWrite   = reg_write & ~rst;
    assign bus.illegal    = illegal_st & ~rst;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: inputs change and outputs are sampled just after negedge.
module tb_mc_control;

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_control_if bus ();

    mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic in_fetch();
        return (bus.ALUSrcB == 2'b10) && (bus.ResultSrc == 2'b10) && (bus.AdrSrc == 1'b0) &&
               (bus.ALUSrcA == 2'b00) && (bus.ALUControl == 3'b000);
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.Zero = 1'b0;
        set_instr(7'd0, 3'd0, 1'b0);
        next_cycle();
        n_tests++;
        if ({bus.PCWrite, bus.IRWrite} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_wen_forced got=%b want=00", {bus.PCWrite, bus.IRWrite});
        end
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        n_tests++;
        if (in_fetch() !== 1'b1 || {bus.PCWrite, bus.IRWrite} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_stall got=%b/%b want=1/00", in_fetch(), {bus.PCWrite, bus.IRWrite});
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({in_fetch(), bus.PCWrite, bus.IRWrite} !== 3'b111) begin
            n_fail++;
            $display("FAIL fetch_ready got=%b want=111", {in_fetch(), bus.PCWrite, bus.IRWrite});
        end
        set_instr(OpSw, 3'b010, 1'b0);
        next_cycle();
        n_tests++;
        if ({bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.IRWrite} !== 7'b01_01_10_0) begin
            n_fail++;
            $display("FAIL decode_ctrl got=%b want=0101100",
                     {bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.IRWrite});
        end
        next_cycle();
        next_cycle();
        bus.mem_ready = 1'b0;
        #1;
        n_tests++;
        if ({bus.MemWrite, bus.AdrSrc} !== 2'b11) begin
            n_fail++;
            $display("FAIL memwrite_wait got=%b want=11", {bus.MemWrite, bus.AdrSrc});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.MemWrite, bus.AdrSrc, bus.ALUSrcB} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_in_memwrite got=%b want=0010",
                     {bus.MemWrite, bus.AdrSrc, bus.ALUSrcB});
        end
        next_cycle();
        n_tests++;
        if ({in_fetch(), bus.MemWrite} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_cycle2 got=%b want=10", {in_fetch(), bus.MemWrite});
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({in_fetch(), bus.MemWrite, bus.IRWrite} !== 3'b100) begin
            n_fail++;
            $display("FAIL after_rst got=%b want=100", {in_fetch(), bus.MemWrite, bus.IRWrite});
        end
    endtask

    task automatic test_rtype_sub();
        set_instr(OpR, 3'b000, 1'b1);
        bus.mem_ready = 1'b1;
        #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cycle();
            n_tests++;
            if (bus.RegWrite !== (c == 4)) begin
                n_fail++;
                $display("FAIL sub_regwrite_c%0d got=%b want=%b", c, bus.RegWrite, (c == 4));
            end
            if (c == 3) begin
                n_tests++;
                if ({bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB} !== 7'b001_10_00) begin
                    n_fail++;
                    $display("FAIL sub_execr got=%b want=0011000",
                             {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB});
                end
            end
            if (c == 4) begin
                n_tests++;
                if (bus.ResultSrc !== 2'b00) begin
                    n_fail++;
                    $display("FAIL sub_aluwb_res got=%b want=00", bus.ResultSrc);
                end
            end
        end
        n_tests++;
        if (in_fetch() !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_back_fetch got=%b want=1", in_fetch());
        end
    endtask

    task automatic test_lw();
        logic mr_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int   n_adr = 0;
        int   n_wb  = 0;
        set_instr(OpLw, 3'b010, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) next_cycle();
            bus.mem_ready = mr_tab[c-1];
            #1;
            if (c < 8 && bus.AdrSrc === 1'b1) n_adr++;
            if (c < 8 && bus.RegWrite === 1'b1 && bus.ResultSrc === 2'b01) n_wb++;
            if (c == 3) begin
                n_tests++;
                if ({bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB} !== 6'b00_10_01) begin
                    n_fail++;
                    $display("FAIL lw_memadr got=%b want=001001",
                             {bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB});
                end
            end
            if (c == 7) begin
                n_tests++;
                if ({bus.RegWrite, bus.ResultSrc} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL lw_memwb got=%b want=101", {bus.RegWrite, bus.ResultSrc});
                end
            end
        end
        n_tests++;
        if (n_adr !== 3) begin
            n_fail++;
            $display("FAIL lw_adrsrc_cycles got=%0d want=3", n_adr);
        end
        n_tests++;
        if (n_wb !== 1) begin
            n_fail++;
            $display("FAIL lw_writebacks got=%0d want=1", n_wb);
        end
        n_tests++;
        if (in_fetch() !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_back_fetch got=%b want=1", in_fetch());
        end
    endtask

    task automatic test_sw();
        logic mr_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   n_mw = 0;
        int   n_rw = 0;
        set_instr(OpSw, 3'b010, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            bus.mem_ready = mr_tab[c-1];
            #1;
            if (bus.MemWrite === 1'b1) n_mw++;
            if (bus.RegWrite !== 1'b0) n_rw++;
            if (c == 3) begin
                n_tests++;
                if (bus.ImmSrc !== 2'b01) begin
                    n_fail++;
                    $display("FAIL sw_immsrc got=%b want=01", bus.ImmSrc);
                end
            end
        end
        n_tests++;
        if (n_mw !== 3) begin
            n_fail++;
            $display("FAIL sw_memwrite_cycles got=%0d want=3", n_mw);
        end
        n_tests++;
        if (n_rw !== 0) begin
            n_fail++;
            $display("FAIL sw_regwrite got=%0d want=0", n_rw);
        end
        n_tests++;
        if (in_fetch() !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_back_fetch got=%b want=1", in_fetch());
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic zero, input logic exp_pc);
        set_instr(OpBr, f3, 1'b0);
        bus.mem_ready = 1'b1;
        bus.Zero = zero;
        #1;
        next_cycle();
        n_tests++;
        if (bus.PCWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL br_decode_pcw f3=%0d got=%b want=0", f3, bus.PCWrite);
        end
        next_cycle();
        n_tests++;
        if ({bus.PCWrite, bus.ALUControl, bus.ResultSrc} !== {exp_pc, 3'b001, 2'b00}) begin
            n_fail++;
            $display("FAIL br_pcwrite f3=%0d z=%b got=%b want=%b", f3, zero,
                     {bus.PCWrite, bus.ALUControl, bus.ResultSrc}, {exp_pc, 3'b001, 2'b00});
        end
        next_cycle();
        n_tests++;
        if (in_fetch() !== 1'b1) begin
            n_fail++;
            $display("FAIL br_back_fetch got=%b want=1", in_fetch());
        end
        bus.Zero = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] alu;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t tab [8] = '{
            '{OpI, 3'b000, 1'b1, 3'b000}, '{OpI, 3'b111, 1'b0, 3'b010},
            '{OpI, 3'b110, 1'b0, 3'b011}, '{OpI, 3'b010, 1'b0, 3'b101},
            '{OpR, 3'b111, 1'b0, 3'b010}, '{OpR, 3'b110, 1'b0, 3'b011},
            '{OpR, 3'b010, 1'b0, 3'b101}, '{OpR, 3'b000, 1'b0, 3'b000}};
        logic [1:0] exp_b;
        for (int i = 0; i < 8; i++) begin
            set_instr(tab[i].op, tab[i].f3, tab[i].f7);
            bus.mem_ready = 1'b1;
            exp_b = (tab[i].op == OpR) ? 2'b00 : 2'b01;
            next_cycle();
            next_cycle();
            n_tests++;
            if ({bus.ALUControl, bus.ALUSrcB, bus.ImmSrc} !== {tab[i].alu, exp_b, 2'b00}) begin
                n_fail++;
                $display("FAIL alu_exec_%0d got=%b want=%b", i,
                         {bus.ALUControl, bus.ALUSrcB, bus.ImmSrc}, {tab[i].alu, exp_b, 2'b00});
            end
            next_cycle();
            n_tests++;
            if ({bus.RegWrite, bus.ResultSrc} !== 3'b100) begin
                n_fail++;
                $display("FAIL alu_wb_%0d got=%b want=100", i, {bus.RegWrite, bus.ResultSrc});
            end
            next_cycle();
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       ill;
    } leg_vec_t;

    task automatic test_legality();
        leg_vec_t tab [10] = '{
            '{OpLw, 3'b000, 1'b0, 1'b1}, '{OpSw, 3'b010, 1'b0, 1'b0},
            '{OpR,  3'b001, 1'b0, 1'b1}, '{OpR,  3'b111, 1'b1, 1'b1},
            '{OpR,  3'b000, 1'b1, 1'b0}, '{OpI,  3'b001, 1'b0, 1'b1},
            '{OpI,  3'b101, 1'b0, 1'b1}, '{OpBr, 3'b100, 1'b0, 1'b1},
            '{OpBr, 3'b001, 1'b0, 1'b0}, '{7'd0, 3'b000, 1'b0, 1'b1}};
        for (int i = 0; i < 10; i++) begin
            set_instr(tab[i].op, tab[i].f3, tab[i].f7);
            bus.mem_ready = 1'b1;
            next_cycle();
            next_cycle();
            n_tests++;
            if (bus.illegal !== tab[i].ill) begin
                n_fail++;
                $display("FAIL legality_%0d got=%b want=%b", i, bus.illegal, tab[i].ill);
            end
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
            #1;
        end
    endtask

    task automatic test_illegal_jal();
        set_instr(OpJal, 3'b000, 1'b0);
        bus.mem_ready = 1'b1;
        bus.Zero = 1'b1;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            n_tests++;
            if ({bus.illegal, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite} !== 5'b10000) begin
                n_fail++;
                $display("FAIL jal_trap_c%0d got=%b want=10000", c,
                         {bus.illegal, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite});
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_rst_illegal got=%b want=0", bus.illegal);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({in_fetch(), bus.illegal, bus.IRWrite} !== 3'b101) begin
            n_fail++;
            $display("FAIL jal_recover got=%b want=101", {in_fetch(), bus.illegal, bus.IRWrite});
        end
        bus.Zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_lw();
        test_sw();
        test_branch(3'b001, 1'b0, 1'b1);
        test_branch(3'b001, 1'b1, 1'b0);
        test_branch(3'b000, 1'b1, 1'b1);
        test_branch(3'b000, 1'b0, 1'b0);
        test_alu_ops();
        test_legality();
        test_illegal_jal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
